// File: rtl/adc_capture_slip.sv
// rtl/adc_capture_slip.sv - armed multi-channel ADC block capture streamed out as one SLIP frame
module adc_capture_slip #(
    parameter int          WIDTH    = 10,
    parameter int          NUM_CH   = 1,
    parameter int          DEPTH    = 256,
    parameter logic [7:0]  FRAME_ID = 8'd2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*WIDTH-1:0]   i_rx_in,
    input  logic                      i_sample_en,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic [7:0]                o_seq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = NUM_CH * WIDTH;

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    // Each emitting state names the byte currently held on o_tx_data.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SOF,
        S_ID,
        S_SEQ,
        S_DATA,
        S_ESC2,
        S_EOF
    } state_t;

    state_t state, state_n;
    state_t esc_from;
    state_t adv_from;

    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] ram_q;
    logic [SW-1:0] cur_word;
    logic [SW-1:0] sel_word;

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW-1:0] k_idx;
    logic [CW-1:0] ch_idx;
    logic          lo_sel;
    logic          data_done;

    logic          cur_esc;
    logic [7:0]    esc_tail;

    logic          xfer;
    logic          wr_en;
    logic          load;
    logic          load_payload;
    logic          take_data;
    logic          frame_done;
    logic          raw_special;
    logic [7:0]    raw_byte;
    logic [7:0]    out_byte;
    logic [7:0]    data_byte;
    logic [7:0]    seq_next;

    logic [WIDTH-1:0] sample;
    logic [15:0]      sample16;

    assign xfer     = o_tx_valid & i_tx_ready;
    assign wr_en    = (state == S_CAPTURE) & i_sample_en;
    assign seq_next = o_seq + 8'd1;
    assign o_busy   = (state != S_IDLE);

    // Sample buffer: one word per instant holds every channel; read is registered.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= i_rx_in;
        end
        ram_q <= mem[rp];
    end

    // Pick the next data byte; the first byte of a word comes straight from the prefetched RAM output.
    always_comb begin
        sel_word = ((ch_idx == '0) && !lo_sel) ? ram_q : cur_word;
        sample   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == CW'(c)) begin
                sample = sel_word[c*WIDTH +: WIDTH];
            end
        end
        sample16              = '0;
        sample16[WIDTH-1:0]   = sample;
        data_byte             = lo_sel ? sample16[7:0] : sample16[15:8];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and selection of the byte to load into the output register.
    always_comb begin
        state_n      = state;
        load         = 1'b0;
        load_payload = 1'b0;
        take_data    = 1'b0;
        frame_done   = 1'b0;
        raw_byte     = 8'h00;
        adv_from     = (state == S_ESC2) ? esc_from : state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_n = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (i_sample_en && (wp == ADDR_LAST)) begin
                    state_n  = S_SOF;
                    load     = 1'b1;
                    raw_byte = SLIP_END;
                end
            end
            S_SOF: begin
                if (xfer) begin
                    state_n      = S_ID;
                    load         = 1'b1;
                    load_payload = 1'b1;
                    raw_byte     = FRAME_ID;
                end
            end
            S_ID, S_SEQ, S_DATA, S_ESC2: begin
                if (xfer) begin
                    if ((state != S_ESC2) && cur_esc) begin
                        state_n  = S_ESC2;
                        load     = 1'b1;
                        raw_byte = esc_tail;
                    end else begin
                        case (adv_from)
                            S_ID: begin
                                state_n      = S_SEQ;
                                load         = 1'b1;
                                load_payload = 1'b1;
                                raw_byte     = seq_next;
                            end
                            S_SEQ: begin
                                state_n      = S_DATA;
                                load         = 1'b1;
                                load_payload = 1'b1;
                                take_data    = 1'b1;
                                raw_byte     = data_byte;
                            end
                            default: begin
                                if (data_done) begin
                                    state_n  = S_EOF;
                                    load     = 1'b1;
                                    raw_byte = SLIP_END;
                                end else begin
                                    state_n      = S_DATA;
                                    load         = 1'b1;
                                    load_payload = 1'b1;
                                    take_data    = 1'b1;
                                    raw_byte     = data_byte;
                                end
                            end
                        endcase
                    end
                end
            end
            S_EOF: begin
                if (xfer) begin
                    state_n    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        raw_special = load_payload && ((raw_byte == SLIP_END) || (raw_byte == SLIP_ESC));
        out_byte    = raw_special ? SLIP_ESC : raw_byte;
    end

    // Output byte register, escape bookkeeping and the completed-frame sequence number.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_seq      <= 8'hFF;
            cur_esc    <= 1'b0;
            esc_tail   <= 8'h00;
            esc_from   <= S_ID;
        end else begin
            if (load) begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= out_byte;
                cur_esc    <= raw_special;
                if (load_payload) begin
                    esc_from <= state_n;
                    esc_tail <= (raw_byte == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
                end
            end else if (xfer) begin
                o_tx_valid <= 1'b0;
            end
            if (frame_done) begin
                o_seq <= seq_next;
            end
        end
    end

    // Write pointer, prefetching read pointer and the data byte walk (instant, channel, half).
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE)) begin
            wp        <= '0;
            rp        <= '0;
            k_idx     <= '0;
            ch_idx    <= '0;
            lo_sel    <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            if (take_data) begin
                if ((ch_idx == '0) && !lo_sel) begin
                    cur_word <= ram_q;
                    rp       <= rp + 1'b1;
                end
                if (!lo_sel) begin
                    lo_sel <= 1'b1;
                end else begin
                    lo_sel <= 1'b0;
                    if (ch_idx == CH_LAST) begin
                        ch_idx <= '0;
                        k_idx  <= k_idx + 1'b1;
                        if (k_idx == ADDR_LAST) begin
                            data_done <= 1'b1;
                        end
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_slip.sv
// tb/tb_adc_capture_slip.sv - self-checking bench for adc_capture_slip
module tb_adc_capture_slip;

    localparam int W = 10;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] rx;
    logic        sen;
    logic        start_a, start_b;
    logic        ready;

    logic        busy_a, valid_a, busy_b, valid_b;
    logic [7:0]  data_a, seq_a, data_b, seq_b;

    logic        busy_m, valid_m;
    logic [7:0]  data_m, seq_m;

    int          cur;
    int          vectors = 0;
    int          errs = 0;

    logic [9:0]  smp [D][2];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  seq_model [2];

    logic        prev_valid, prev_ready;
    logic [7:0]  prev_data;

    logic [7:0]  lit_a [20] = '{8'hC0, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01,
                                8'h01, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00, 8'h03, 8'h01, 8'h03, 8'hC0};
    logic [7:0]  lit_b [16] = '{8'hC0, 8'hDB, 8'hDC, 8'h00, 8'h00, 8'hDB, 8'hDC, 8'h00,
                                8'hDB, 8'hDD, 8'h03, 8'hDB, 8'hDC, 8'h00, 8'h00, 8'hC0};

    always #5 clk = ~clk;

    adc_capture_slip #(.WIDTH(W), .NUM_CH(2), .DEPTH(D), .FRAME_ID(8'h02)) u_a (
        .clk(clk), .reset(reset), .i_rx_in(rx), .i_sample_en(sen), .i_start(start_a),
        .o_busy(busy_a), .o_tx_data(data_a), .o_tx_valid(valid_a), .i_tx_ready(ready), .o_seq(seq_a)
    );

    adc_capture_slip #(.WIDTH(W), .NUM_CH(1), .DEPTH(D), .FRAME_ID(8'hC0)) u_b (
        .clk(clk), .reset(reset), .i_rx_in(rx[9:0]), .i_sample_en(sen), .i_start(start_b),
        .o_busy(busy_b), .o_tx_data(data_b), .o_tx_valid(valid_b), .i_tx_ready(ready), .o_seq(seq_b)
    );

    always_comb begin
        busy_m  = (cur == 1) ? busy_b  : busy_a;
        valid_m = (cur == 1) ? valid_b : valid_a;
        data_m  = (cur == 1) ? data_b  : data_a;
        seq_m   = (cur == 1) ? seq_b   : seq_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void pay(input logic [7:0] b);
        if (b == 8'hC0) begin
            exp_q.push_back(8'hDB);
            exp_q.push_back(8'hDC);
        end else if (b == 8'hDB) begin
            exp_q.push_back(8'hDB);
            exp_q.push_back(8'hDD);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    function automatic void build_expected(input int nch, input logic [7:0] id, input logic [7:0] sq);
        logic [15:0] v;
        exp_q.delete();
        exp_q.push_back(8'hC0);
        pay(id);
        pay(sq);
        for (int k = 0; k < D; k++) begin
            for (int c = 0; c < nch; c++) begin
                v = {6'd0, smp[k][c]};
                pay(v[15:8]);
                pay(v[7:0]);
            end
        end
        exp_q.push_back(8'hC0);
    endfunction

    function automatic logic [9:0] pick();
        case ($urandom_range(4, 0))
            0: return 10'h0C0;
            1: return 10'h0DB;
            2: return 10'h3C0;
            3: return 10'h2DB;
            default: return 10'($urandom);
        endcase
    endfunction

    function automatic void random_samples();
        for (int k = 0; k < D; k++) begin
            smp[k][0] = pick();
            smp[k][1] = pick();
        end
    endfunction

    task automatic step(input int rdy_pct);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        sen     = 1'b0;
        rx      = 20'($urandom);
        if (prev_valid && !prev_ready) begin
            check("hold_valid", {31'd0, valid_m}, 32'd1);
            check("hold_data", {24'd0, data_m}, {24'd0, prev_data});
        end
        ready = ($urandom_range(99, 0) < rdy_pct);
        if (valid_m && ready) got_q.push_back(data_m);
        prev_valid = valid_m;
        prev_ready = ready;
        prev_data  = data_m;
    endtask

    task automatic pulse_start(input int which);
        if (which == 1) start_b = 1'b1;
        else start_a = 1'b1;
    endtask

    task automatic run_frame(input int which, input int rdy_pct, input int max_gap, input bit poke);
        int  n;
        bit  seen;
        bit  poked;
        cur = which;
        build_expected((which == 1) ? 1 : 2, (which == 1) ? 8'hC0 : 8'h02, seq_model[which] + 8'd1);
        got_q.delete();
        step(rdy_pct);
        pulse_start(which);
        sen = 1'b1;
        for (int k = 0; k < D; k++) begin
            n = $urandom_range(max_gap, 0);
            for (int g = 0; g < n; g++) step(rdy_pct);
            step(rdy_pct);
            if (poke && k == 2) pulse_start(which);
            sen = 1'b1;
            rx  = {smp[k][1], smp[k][0]};
        end
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(rdy_pct);
            if (valid_m) seen = 1'b1;
        end
        check("first_byte_latency", {31'd0, seen}, 32'd1);
        n = 0;
        poked = 1'b0;
        while (busy_m && n < 3000) begin
            step(rdy_pct);
            if (poke && !poked && got_q.size() >= 6) begin
                pulse_start(which);
                poked = 1'b1;
            end
            n++;
        end
        check("busy_low_at_end", {31'd0, busy_m}, 32'd0);
        check("valid_low_at_end", {31'd0, valid_m}, 32'd0);
        check("frame_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("frame_byte%0d", i),
                  (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        end
        seq_model[which] = seq_model[which] + 8'd1;
        check("o_seq", {24'd0, seq_m}, {24'd0, seq_model[which]});
    endtask

    initial begin
        reset = 1'b1; ready = 1'b1; sen = 1'b0; start_a = 1'b0; start_b = 1'b0; rx = '0; cur = 0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = 8'h00;
        seq_model[0] = 8'hFF; seq_model[1] = 8'hFF;
        step(100);
        step(100);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_valid_a", {31'd0, valid_a}, 32'd0);
        check("rst_data_a", {24'd0, data_a}, 32'h00);
        check("rst_seq_a", {24'd0, seq_a}, 32'hFF);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);
        check("rst_seq_b", {24'd0, seq_b}, 32'hFF);
        reset = 1'b0;
        step(100);

        // Directed two-channel frame, ready always high.
        for (int k = 0; k < D; k++) begin
            smp[k][0] = 10'(k);
            smp[k][1] = 10'(10'h100 + k);
        end
        run_frame(0, 100, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            check($sformatf("lit_a%0d", i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, lit_a[i]});

        // Escape frame on the single-channel instance with FRAME_ID = C0.
        smp[0][0] = 10'h0C0; smp[1][0] = 10'h0DB; smp[2][0] = 10'h3C0; smp[3][0] = 10'h000;
        run_frame(1, 100, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("lit_b%0d", i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, lit_b[i]});

        // Backpressure, sample gaps and ignored start pulses.
        for (int f = 0; f < 3; f++) begin
            random_samples();
            run_frame(0, 30, 20, 1'b1);
        end
        for (int f = 0; f < 2; f++) begin
            random_samples();
            run_frame(1, 30, 20, 1'b1);
        end

        // Reset in the middle of the data phase.
        cur = 0;
        random_samples();
        got_q.delete();
        step(100);
        start_a = 1'b1;
        for (int k = 0; k < D; k++) begin
            step(100);
            sen = 1'b1;
            rx  = {smp[k][1], smp[k][0]};
        end
        for (int i = 0; i < 200 && got_q.size() < 7; i++) step(100);
        check("mid_data_reached", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        step(100);
        check("mid_rst_valid", {31'd0, valid_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_seq", {24'd0, seq_a}, 32'hFF);
        reset = 1'b0;
        prev_valid = 1'b0;
        seq_model[0] = 8'hFF; seq_model[1] = 8'hFF;
        random_samples();
        run_frame(0, 60, 3, 1'b0);

        // 257 back-to-back frames wrap the sequence number.
        reset = 1'b1;
        step(100);
        step(100);
        reset = 1'b0;
        prev_valid = 1'b0;
        seq_model[0] = 8'hFF; seq_model[1] = 8'hFF;
        for (int f = 0; f < 257; f++) begin
            random_samples();
            run_frame(0, 100, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
